// File: rtl/dut_reg_responder.sv
// dut_reg_responder: register-bank responder for a one-outstanding request/response protocol with fixed latency
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb request channel;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel; busy = a request is in flight.
// Option: define DUT_RSP_ADDR_CHECK_EN to flag out-of-range requests on rsp_err (tied to 0 otherwise).
module dut_reg_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 12,
  parameter int RSP_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);
  localparam int CW = $clog2(RSP_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic acc, oor;
  assign acc = req_valid && req_ready;
  assign oor = 32'(req_addr) >= NUM_REGS;
  // req_ready is registered from the next state so it rises on the handshake edge and after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
    end else begin
      state     <= nxt;
      req_ready <= nxt == IDLE;
    end
  always_comb
    nxt = state == IDLE ? (acc ? (RSP_LAT == 1 ? RESP : WAIT) : IDLE) :
          state == WAIT ? (cnt == CW'(1) ? RESP : WAIT) :
          (rsp_ready ? IDLE : RESP);
  always_comb begin
    rsp_valid = state == RESP;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (acc) cnt <= CW'(RSP_LAT - 1);
    else if (state == WAIT) cnt <= cnt - CW'(1);
  // the bank is written and the read data captured on the accept edge, so the response is fixed from then on
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      rsp_rdata <= '0;
    end else if (acc) begin
      if (req_write && !oor)
        for (int b = 0; b < DATA_W / 8; b++)
          if (req_wstrb[b]) regs[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      rsp_rdata <= (!req_write && !oor) ? regs[req_addr] : '0;
    end
`ifdef DUT_RSP_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_err <= 1'b0;
    else if (acc) rsp_err <= oor;
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_dut_reg_responder.sv
// tb_dut_reg_responder: randomized self-checking bench for dut_reg_responder against an array reference model
module tb_dut_reg_responder;
  localparam int DW = 32, AW = 4, NR = 12, LAT = 2;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW/8-1:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] model [NR];
  int checks = 0, failures = 0;
  dut_reg_responder #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RSP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic exp_err(input int a);
`ifdef DUT_RSP_ADDR_CHECK_EN
    return a >= NR;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [DW-1:0] exp_data(input logic w, input int a);
    return (!w && a < NR) ? model[a] : '0;
  endfunction
  task automatic model_write(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    if (a < NR)
      for (int b = 0; b < DW / 8; b++)
        if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_timeout", req_ready, 1'b1);
  endtask
  task automatic xact(input logic w, input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                      input int hold, input logic early);
    logic [DW-1:0] ed;
    logic ee;
    int lat;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = AW'(a); req_wdata = d; req_wstrb = s;
    wait_ready();
    ed = exp_data(w, a);
    ee = exp_err(a);
    if (w) model_write(a, d, s);
    rsp_ready = early;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      chk("busy_wait", busy, 1'b1);
      chk("req_ready_wait", req_ready, 1'b0);
      @(negedge clk); lat++;
    end
    chk("latency", lat, LAT);
    chk("rdata", rsp_rdata, ed);
    chk("err", rsp_err, ee);
    rsp_ready = 0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      req_addr = AW'($urandom);
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, ed);
      chk("hold_err", rsp_err, ee);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("post_valid", rsp_valid, 1'b0);
    chk("post_req_ready", req_ready, 1'b1);
    chk("post_busy", busy, 1'b0);
  endtask
  initial begin
    for (int r = 0; r < NR; r++) model[r] = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst_n = 1;
    #1 chk("release_req_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("first_edge_req_ready", req_ready, 1'b1);
    chk("idle_valid", rsp_valid, 1'b0);
    for (int r = 0; r < NR; r++) xact(0, r, '0, '0, 0, 0);
    xact(1, 3, 32'hDEADBEEF, 4'hF, 0, 0);
    xact(0, 3, '0, '0, 0, 0);
    chk("full_write_val", model[3], 32'hDEADBEEF);
    xact(1, 3, 32'h0000AA00, 4'h2, 0, 1);
    xact(0, 3, '0, '0, 0, 0);
    chk("partial_write_val", rsp_rdata, 32'hDEADAAEF);
    xact(0, 3, '0, '0, 5, 0);
    xact(1, 7, 32'h12345678, 4'h0, 1, 0);
    xact(1, 14, 32'hFFFFFFFF, 4'hF, 2, 0);
    xact(0, 14, '0, '0, 0, 1);
    for (int r = 0; r < NR; r++) xact(0, r, '0, '0, 0, 1);
    for (int k = 0; k < 60; k++)
      xact(1'($urandom), int'($urandom_range(0, 15)), $urandom, 4'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom));
    for (int r = 0; r < NR; r++) xact(0, r, '0, '0, 0, 0);
    xact(1, 5, 32'hCAFEF00D, 4'hF, 0, 0);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 4'd5;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("abort_busy_before", busy, 1'b1);
    rst_n = 0;
    #1;
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_req_ready", req_ready, 1'b0);
    chk("abort_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < NR; r++) model[r] = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);
    end
    xact(0, 5, '0, '0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dut_reg_responder.md
Name: dut_reg_responder

Overview:
- DUT-side responder for the bench's request/response interface: the bench initiates register reads and writes, and this block accepts them, executes them against a local register bank and returns responses after a fixed latency.
- Sits behind dut_intf in top as the responding end of the protocol; one outstanding request at a time.
- Gives the verification environment a DUT with real handshake, latency and back-pressure behaviour.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, request address width.
- NUM_REGS, 12, number of implemented registers; must be ≥1 and ≤ 2**ADDR_W.
- RSP_LAT, 2, cycles from request accept edge to rsp_valid assertion; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  register index.
- req_wdata  input  DATA_W  write data.
- req_wstrb  input  DATA_W/8  byte enables for writes.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  bench accepts the response.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  address error (see Optional Feature).
- busy  output  1  a request is in flight (state ≠ IDLE).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; all registers = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, latency counter = 0.
  - req_ready is registered and rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept when req_valid && req_ready at a rising edge.
  - On accept: capture req_write and req_addr; req_ready drops the next cycle.
  - If RSP_LAT == 1, go to RESP; otherwise go to WAIT with counter = RSP_LAT-1.
- Write at the accept edge:
  - For an in-range address, register byte i is updated iff req_wstrb[i].
  - req_wstrb == 0 means no change, but a response is still returned.
- Read at the accept edge:
  - The register value is captured into the response data register at the accept edge.
  - Read-after-write ordering is therefore guaranteed: only one request is ever outstanding.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, go to RESP.
  - rsp_valid first asserts exactly RSP_LAT cycles after the accept edge.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On the handshake: go to IDLE; rsp_valid drops and req_ready rises on the same edge.
  - A new request is accepted one cycle after the response handshake at the earliest, so accept and response never share a cycle.
- rsp_ready may be held high before rsp_valid; this does not shorten the latency.
- req_valid asserted outside IDLE is ignored; the bench must keep it asserted until accepted.
- Out-of-range address (req_addr ≥ NUM_REGS):
  - Writes have no effect.
  - Reads return 0.
  - rsp_err is set per Optional Feature.
- Reset mid-transaction aborts the transaction: no response is produced and register contents return to 0.
- Counter width is $clog2(RSP_LAT+1); it never wraps.

Optional Feature:
- Macro: DUT_RSP_ADDR_CHECK_EN.
- Defined: rsp_err = 1 in the response of any out-of-range request, read or write; 0 otherwise.
- Undefined: rsp_err is tied to 0. Out-of-range accesses behave identically otherwise (write dropped, read returns 0).

Test Plan:
- Reset then idle: rsp_valid = 0 and busy = 0 throughout; req_ready = 0 during reset and = 1 from the first edge after release; reading regs 0..11 returns 0.
- Write addr 3 = 0xDEADBEEF (wstrb 0xF), then read addr 3 with RSP_LAT = 2: each rsp_valid occurs 2 cycles after its accept; rdata = 0xDEADBEEF, rsp_err = 0.
- Partial write wstrb 0x2, data 0x0000AA00, to addr 3 after the previous write: read returns 0xDEADAAEF.
- rsp_ready held low 5 cycles during RESP: rsp_valid and rdata stay stable, req_ready stays 0, and req_valid pulses are ignored; after the handshake, the next request is accepted one cycle later.
- Read and write to addr 14:
  - With macro: rsp_err = 1, rdata = 0.
  - Without macro: rsp_err = 0, rdata = 0.
  - In both cases regs 0..11 are unchanged.
- rst_n asserted during WAIT: outputs clear immediately and no response follows; the register written before reset reads back 0.
